// File: rtl/ctrl_pkg.sv
// Shared encodings for the CPU control FSM: states, condition codes,
// instruction classes and the compare-opcode range.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_MEM    = 4'd3,
    ST_WB     = 4'd4,
    ST_HALT   = 4'd5
  } state_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] TYPE_DP    = 2'b00;
  localparam logic [1:0] TYPE_LS    = 2'b01;
  localparam logic [1:0] TYPE_BR    = 2'b10;
  localparam logic [1:0] TYPE_UNDEF = 2'b11;

  // TST/TEQ/CMP/CMN only update flags and never write a register.
  localparam logic [3:0] CMP_OP_LO = 4'b1000;
  localparam logic [3:0] CMP_OP_HI = 4'b1011;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

  function automatic logic is_compare_op(input logic [3:0] op);
    return (op >= CMP_OP_LO) && (op <= CMP_OP_HI);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code check: only EQ, NE and AL can pass.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  // N, C and V play no part in the supported conditions.
  logic flags_unused;
  assign flags_unused = ^{flags[3], flags[1:0]};

  // Evaluate the condition against the Z flag.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = flags[2];
      COND_NE: pass = ~flags[2];
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/writeback with a
// memory-ack timeout, sticky halt/fault flags and a retired-instruction count.
module cpu_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned RET_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       cond,
  input  logic [1:0]       types,
  input  logic [3:0]       opcode,
  input  logic             load_bit,
  input  logic [3:0]       flags,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_load,
  output logic             alu_en,
  output logic             flag_we,
  output logic             reg_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             halted,
  output logic             fault,
  output logic [RET_W-1:0] retired,
  output logic [3:0]       state
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d, wait_inc;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic             run_q;
  logic             cond_pass;

  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  // Next-state, wait counter, sticky flags and per-state datapath strobes.
  // run_q keeps everything quiet for the cycle right after a reset edge.
  always_comb begin
    state_d  = state_q;
    wait_d   = 4'd0;
    halted_d = halted_q;
    fault_d  = fault_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_load  = 1'b0;
    alu_en   = 1'b0;
    flag_we  = 1'b0;
    reg_we   = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    wait_inc = wait_q + 4'd1;
    if (run_q) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load = 1'b1;
            state_d = ST_DECODE;
          end else if (wait_inc == TIMEOUT_CNT) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
            fault_d  = 1'b1;
          end else begin
            wait_d = wait_inc;
          end
        end
        ST_DECODE: begin
          if (!cond_pass) begin
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
          end else if (types == TYPE_UNDEF) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_en = 1'b1;
          case (types)
            TYPE_DP: begin
              if (is_compare_op(opcode)) begin
                flag_we = 1'b1;
                pc_inc  = 1'b1;
                state_d = ST_FETCH;
              end else begin
                state_d = ST_WB;
              end
            end
            TYPE_LS: state_d = ST_MEM;
            TYPE_BR: begin
              pc_load = 1'b1;
              state_d = ST_FETCH;
            end
            default: begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = ~load_bit;
          if (dmem_ack) begin
            if (load_bit) begin
              state_d = ST_WB;
            end else begin
              pc_inc  = 1'b1;
              state_d = ST_FETCH;
            end
          end else if (wait_inc == TIMEOUT_CNT) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
            fault_d  = 1'b1;
          end else begin
            wait_d = wait_inc;
          end
        end
        ST_WB: begin
          reg_we  = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_FETCH;
      endcase
    end else begin
      state_d = ST_FETCH;
    end
    if (pc_inc || pc_load) begin
      retired_d = retired_q + RET_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      wait_q    <= 4'd0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= '0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      run_q     <= 1'b1;
    end
  end

  assign halted  = halted_q;
  assign fault   = fault_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: an instruction-level reference
// model expands each instruction into its expected per-cycle trace.
module tb_cpu_controller;
  import ctrl_pkg::*;

  localparam int TMO = 15;
  localparam int RW  = 8;

  localparam logic [8:0] V_NONE  = 9'h000;
  localparam logic [8:0] V_IREQ  = 9'h100;
  localparam logic [8:0] V_DREQ  = 9'h080;
  localparam logic [8:0] V_DWE   = 9'h040;
  localparam logic [8:0] V_IRLD  = 9'h020;
  localparam logic [8:0] V_ALU   = 9'h010;
  localparam logic [8:0] V_FLAG  = 9'h008;
  localparam logic [8:0] V_REGWE = 9'h004;
  localparam logic [8:0] V_PCINC = 9'h002;
  localparam logic [8:0] V_PCLD  = 9'h001;

  typedef struct packed {
    logic       iack;
    logic       dack;
    logic [3:0] st;
    logic [8:0] exp;
  } rec_t;

  logic          clk, rst_n;
  logic [3:0]    cond, opcode, flags;
  logic [1:0]    types;
  logic          load_bit, imem_ack, dmem_ack;
  logic          imem_req, dmem_req, dmem_we, ir_load, alu_en, flag_we;
  logic          reg_we, pc_inc, pc_load, halted, fault;
  logic [RW-1:0] retired;
  logic [3:0]    state;
  logic [8:0]    outs;

  rec_t          trace[$];
  logic [RW-1:0] exp_ret;
  logic          exp_halted, exp_fault;
  int            n_checks, n_errors;

  assign outs = {imem_req, dmem_req, dmem_we, ir_load, alu_en, flag_we, reg_we, pc_inc, pc_load};

  cpu_controller #(.TIMEOUT(TMO), .RET_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .types(types), .opcode(opcode),
    .load_bit(load_bit), .flags(flags), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_load(ir_load),
    .alu_en(alu_en), .flag_we(flag_we), .reg_we(reg_we), .pc_inc(pc_inc),
    .pc_load(pc_load), .halted(halted), .fault(fault), .retired(retired), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Acks on a port whose request is low are randomised: they must be ignored.
  task automatic push(input logic ia, input logic da, input state_e st, input logic [8:0] v);
    rec_t r;
    r.iack = ((v & V_IREQ) != V_NONE) ? ia : 1'($urandom);
    r.dack = ((v & V_DREQ) != V_NONE) ? da : 1'($urandom);
    r.st   = st;
    r.exp  = v;
    trace.push_back(r);
  endtask

  // Instruction-level model. ending: 0 normal, 1 undefined-halt, 2 timeout.
  task automatic build(input logic [3:0] c, input logic [1:0] t, input logic [3:0] op,
                       input logic lb, input logic [3:0] fl, input int di, input int dd,
                       output int ending);
    logic       pass;
    logic [8:0] memv;
    ending   = 0;
    cond     = c;
    types    = t;
    opcode   = op;
    load_bit = lb;
    flags    = fl;
    pass = ((c == 4'd0) && fl[2]) || ((c == 4'd1) && !fl[2]) || (c == 4'd14);
    for (int i = 0; i < di && i < TMO; i++) push(1'b0, 1'b0, ST_FETCH, V_IREQ);
    if (di >= TMO) begin
      ending = 2;
      return;
    end
    push(1'b1, 1'b0, ST_FETCH, V_IREQ | V_IRLD);
    if (!pass) begin
      push(1'b0, 1'b0, ST_DECODE, V_PCINC);
      return;
    end
    push(1'b0, 1'b0, ST_DECODE, V_NONE);
    if (t == 2'd3) begin
      ending = 1;
      return;
    end
    if (t == 2'd0) begin
      if (op >= 4'd8 && op <= 4'd11) begin
        push(1'b0, 1'b0, ST_EXEC, V_ALU | V_FLAG | V_PCINC);
      end else begin
        push(1'b0, 1'b0, ST_EXEC, V_ALU);
        push(1'b0, 1'b0, ST_WB, V_REGWE | V_PCINC);
      end
    end else if (t == 2'd2) begin
      push(1'b0, 1'b0, ST_EXEC, V_ALU | V_PCLD);
    end else begin
      push(1'b0, 1'b0, ST_EXEC, V_ALU);
      memv = V_DREQ | (lb ? V_NONE : V_DWE);
      for (int i = 0; i < dd && i < TMO; i++) push(1'b0, 1'b0, ST_MEM, memv);
      if (dd >= TMO) begin
        ending = 2;
        return;
      end
      if (lb) begin
        push(1'b0, 1'b1, ST_MEM, memv);
        push(1'b0, 1'b0, ST_WB, V_REGWE | V_PCINC);
      end else begin
        push(1'b0, 1'b1, ST_MEM, memv | V_PCINC);
      end
    end
  endtask

  // Play up to n_max records; entered and left just after a rising edge.
  task automatic run_trace(input int n_max);
    rec_t r;
    int   n;
    n = 0;
    while (trace.size() > 0 && n < n_max) begin
      r = trace.pop_front();
      imem_ack = r.iack;
      dmem_ack = r.dack;
      @(negedge clk);
      chk("outs", 32'(outs), 32'(r.exp));
      chk("state", 32'(state), 32'(r.st));
      chk("retired", 32'(retired), 32'(exp_ret));
      chk("halted", 32'(halted), 32'(exp_halted));
      chk("fault", 32'(fault), 32'(exp_fault));
      @(posedge clk);
      #1;
      if ((r.exp & (V_PCINC | V_PCLD)) != V_NONE) exp_ret = exp_ret + RW'(1);
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'($urandom);
    dmem_ack = 1'($urandom);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(ST_FETCH));
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_ret    = '0;
    exp_halted = 1'b0;
    exp_fault  = 1'b0;
  endtask

  task automatic instr(input logic [3:0] c, input logic [1:0] t, input logic [3:0] op,
                       input logic lb, input logic [3:0] fl, input int di, input int dd);
    int ending;
    build(c, t, op, lb, fl, di, dd, ending);
    run_trace(1000);
    if (ending != 0) begin
      exp_halted = 1'b1;
      exp_fault  = (ending == 2);
      for (int i = 0; i < 3; i++) push(1'b0, 1'b0, ST_HALT, V_NONE);
      run_trace(100);
      do_reset();
    end
  endtask

  initial begin
    int ending, di, dd;
    logic [1:0] t;
    logic [3:0] c;
    n_checks   = 0;
    n_errors   = 0;
    exp_ret    = '0;
    exp_halted = 1'b0;
    exp_fault  = 1'b0;
    cond = 4'd0; types = 2'd0; opcode = 4'd0; load_bit = 1'b0; flags = 4'd0;
    do_reset();

    // Directed cases.
    instr(4'b1110, 2'b00, 4'b0100, 1'b0, 4'b0000, 2, 0);   // ADD, ack after 2
    chk("add_retired", 32'(retired), 32'd1);
    instr(4'b0000, 2'b00, 4'b0100, 1'b0, 4'b0000, 1, 0);   // EQ with Z=0: skip
    instr(4'b0000, 2'b00, 4'b1010, 1'b0, 4'b0100, 0, 0);   // EQ with Z=1: CMP
    instr(4'b0001, 2'b00, 4'b0100, 1'b0, 4'b0000, 0, 0);   // NE with Z=0: pass
    instr(4'b1110, 2'b01, 4'b0000, 1'b1, 4'b0000, 0, 3);   // LDR
    instr(4'b1110, 2'b01, 4'b0000, 1'b0, 4'b0000, 1, 2);   // STR
    instr(4'b1110, 2'b10, 4'b0000, 1'b0, 4'b0000, 0, 0);   // branch
    instr(4'b1110, 2'b00, 4'b0001, 1'b0, 4'b0000, 14, 0);  // imem ack on last allowed cycle
    instr(4'b1110, 2'b01, 4'b0000, 1'b1, 4'b0000, 0, 14);  // dmem ack on last allowed cycle
    instr(4'b1110, 2'b01, 4'b0000, 1'b1, 4'b0000, 0, 15);  // dmem timeout
    instr(4'b1110, 2'b00, 4'b0000, 1'b0, 4'b0000, 15, 0);  // imem timeout
    instr(4'b1110, 2'b11, 4'b0000, 1'b0, 4'b0000, 1, 0);   // undefined -> halt

    // Randomised instruction stream.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0:       c = 4'b0000;
        1:       c = 4'b0001;
        2:       c = 4'b1110;
        default: c = 4'($urandom);
      endcase
      t  = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      di = ($urandom_range(0, 15) == 0) ? 14 : int'($urandom_range(0, 4));
      dd = ($urandom_range(0, 15) == 0) ? 14 : int'($urandom_range(0, 4));
      instr(c, t, 4'($urandom), 1'($urandom), 4'($urandom), di, dd);
    end

    // Reset in the middle of a data-memory wait.
    instr(4'b1110, 2'b00, 4'b0100, 1'b0, 4'b0000, 0, 0);
    build(4'b1110, 2'b01, 4'b0000, 1'b1, 4'b0000, 0, 10, ending);
    run_trace(6);
    trace.delete();
    do_reset();

    // Retired counter wrap at 2^RW-1.
    while (exp_ret != {RW{1'b1}}) instr(4'b0101, 2'b00, 4'b0000, 1'b0, 4'b0000, 0, 0);
    chk("ret_max", 32'(retired), 32'(2**RW - 1));
    instr(4'b1110, 2'b10, 4'b0000, 1'b0, 4'b0000, 0, 0);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("ret_wrap", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles a memory request waits for ack before fault.
REQ-002 SHALL have parameter RET_W, default 16, retired-instruction counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 cond  input  4  decoded condition field.
REQ-006 types  input  2  decoded class (00 data-proc, 01 load/store, 10 branch, 11 undefined).
REQ-007 opcode  input  4  decoded data-processing opcode.
REQ-008 load_bit  input  1  ir[20] (1 = load, 0 = store for types 01).
REQ-009 flags  input  4  current NZCV (Z = flags[2]).
REQ-010 imem_ack / dmem_ack  input  1 each  memory completion strobes.
REQ-011 imem_req, dmem_req, dmem_we  output  1 each  memory request / store enable.
REQ-012 ir_load, alu_en, flag_we, reg_we, pc_inc, pc_load  output  1 each  single-cycle datapath strobes.
REQ-013 halted, fault  output  1 each  sticky stop / timeout indicators.
REQ-014 retired  output  RET_W  completed-instruction count.
REQ-015 state  output  4  current FSM state encoding, for debug.

Function
REQ-016 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-017 FETCH: imem_req=1 held until imem_ack; ack cycle pulses ir_load and moves to DECODE.
REQ-018 DECODE (1 cycle): cond pass = EQ(0000)&Z | NE(0001)&~Z | AL(1110); any other cond is fail.
REQ-019 DECODE, cond fail: pulse pc_inc, go FETCH (skipped instruction still counts as retired).
REQ-020 DECODE, cond pass, types 11: go HALT, halted=1, fault=0.
REQ-021 DECODE, cond pass, otherwise: go EXEC.
REQ-022 EXEC (1 cycle): alu_en=1; types 00 with opcode 1000-1011 (TST/TEQ/CMP/CMN) pulses flag_we, pc_inc, go FETCH; other types 00 go WB.
REQ-023 EXEC types 01: go MEM; types 10: pulse pc_load, go FETCH.
REQ-024 MEM: dmem_req=1, dmem_we=~load_bit, held until dmem_ack; on ack, load goes WB, store pulses pc_inc and goes FETCH.
REQ-025 WB (1 cycle): pulse reg_we and pc_inc, go FETCH.
REQ-026 Acks SHALL be ignored when the matching req is low; req SHALL not deassert before ack.
REQ-027 4-bit wait counter clears on entry to FETCH/MEM, increments each req-high cycle without ack; reaching TIMEOUT without ack in that cycle -> HALT, fault=1, req dropped next cycle.
REQ-028 Ack on the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-029 retired increments by 1 in every cycle pc_inc or pc_load is asserted; wraps 2^RET_W-1 -> 0.
REQ-030 pc_inc and pc_load SHALL never assert together; HALT exits only through reset.

Reset
REQ-031 rst_n low at a clock edge SHALL force state FETCH, all strobes/reqs 0, halted=0, fault=0, retired=0, wait counter 0, including mid-request.
REQ-032 First imem_req SHALL assert the first cycle after rst_n sampled high.

Structure
REQ-033 Package ctrl_pkg SHALL hold state enum, cond codes (EQ, NE, AL), type codes, compare-opcode range, default TIMEOUT.
REQ-034 Sub-module cond_eval (combinational cond+flags -> pass) SHALL be the single instantiated child.

Verification
REQ-035 ADD (cond 1110, types 00, opcode 0100), imem_ack after 2 cycles -> ir_load, alu_en, reg_we+pc_inc in WB; retired=1.
REQ-036 cond 0000, flags Z=0 -> DECODE pc_inc, no alu_en/reg_we; with Z=1, CMP (opcode 1010) -> flag_we, no reg_we.
REQ-037 LDR (types 01, load_bit 1), dmem_ack after 3 cycles -> dmem_we=0, then WB reg_we; STR -> dmem_we=1, no reg_we.
REQ-038 Branch (types 10, cond 1110) -> pc_load in EXEC, next cycle FETCH; retired +1.
REQ-039 dmem_ack withheld 15 cycles -> HALT, fault=1, dmem_req low after; types 11 -> halted=1, fault=0.
REQ-040 rst_n low during MEM wait -> next cycle state FETCH, dmem_req=0, retired=0; preload retired=16'hFFFF, one retire -> 0.
